// File: rtl/rst_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : rst_seq_ctrl_if
// Description : Control/status bundle between the reset sequencer and its user.
// Revision    : 1.0 - initial release
// ============================================================================
interface rst_seq_ctrl_if #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 16
);
    logic              sw_rst_req;
    logic              run_en;
    logic [NUM_CH-1:0] ch_rst;
    logic              all_released;
    logic              stop_req;
    logic [CNT_W-1:0]  cycle_cnt;
    logic [1:0]        state;

    modport master (
        output sw_rst_req,
        output run_en,
        input  ch_rst,
        input  all_released,
        input  stop_req,
        input  cycle_cnt,
        input  state
    );

    modport slave (
        input  sw_rst_req,
        input  run_en,
        output ch_rst,
        output all_released,
        output stop_req,
        output cycle_cnt,
        output state
    );
endinterface
`default_nettype wire

// File: rtl/rst_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rst_seq_ctrl
// Description : Staggered multi-channel reset release with run-phase timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module rst_seq_ctrl #(
    parameter int NUM_CH         = 2,
    parameter int HOLD_CYCLES    = 10,
    parameter int STAGGER_CYCLES = 4,
    parameter int RUN_CYCLES     = 500,
    parameter int CNT_W          = 16
) (
    input  wire logic      clk,
    input  wire logic      rst,
    rst_seq_ctrl_if.slave  bus
);
    localparam logic [1:0] c_st_hold    = 2'd0;
    localparam logic [1:0] c_st_release = 2'd1;
    localparam logic [1:0] c_st_run     = 2'd2;
    localparam logic [1:0] c_st_stopped = 2'd3;

    // One counter serves both the hold phase and the stagger gaps.
    localparam int c_seq_max = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
    localparam int c_seq_w   = $clog2(c_seq_max + 1);

    localparam logic [c_seq_w-1:0] c_hold_last = c_seq_w'(HOLD_CYCLES - 1);
    localparam logic [c_seq_w-1:0] c_stg_last  =
        c_seq_w'((STAGGER_CYCLES == 0) ? 0 : STAGGER_CYCLES - 1);
    localparam logic [c_seq_w-1:0] c_seq_one   = c_seq_w'(1);
    localparam logic [63:0]        c_run_target = 64'(RUN_CYCLES);
    localparam logic [CNT_W-1:0]   c_cnt_max    = '1;
    localparam logic [CNT_W-1:0]   c_cnt_one    = CNT_W'(1);

    logic [1:0]         r_state;
    logic [c_seq_w-1:0] r_seq;
    logic [NUM_CH-1:0]  r_ch_rst;
    logic               r_all_released;
    logic               r_stop_req;
    logic [CNT_W-1:0]   r_cnt;

    logic [NUM_CH-1:0]  w_ch_shift;
    logic [NUM_CH-1:0]  w_hold_next;
    logic               w_cnt_sat;
    logic               w_timeout;

    // Shifting left clears the lowest channel still in reset, giving ascending order.
    assign w_ch_shift  = r_ch_rst << 1;
    assign w_hold_next = (STAGGER_CYCLES == 0) ? '0 : w_ch_shift;
    assign w_cnt_sat   = (r_cnt == c_cnt_max);
    assign w_timeout   = (RUN_CYCLES != 0) && bus.run_en && !w_cnt_sat &&
                         ((64'(r_cnt) + 64'd1) == c_run_target);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= c_st_hold;
            r_seq          <= '0;
            r_ch_rst       <= '1;
            r_all_released <= 1'b0;
            r_stop_req     <= 1'b0;
            r_cnt          <= '0;
        end else if (bus.sw_rst_req) begin
            r_state        <= c_st_hold;
            r_seq          <= '0;
            r_ch_rst       <= '1;
            r_all_released <= 1'b0;
            r_stop_req     <= 1'b0;
            r_cnt          <= '0;
        end else begin
            case (r_state)
                c_st_hold: begin
                    if (r_seq == c_hold_last) begin
                        r_seq    <= '0;
                        r_ch_rst <= w_hold_next;
                        if (w_hold_next == '0) begin
                            r_all_released <= 1'b1;
                            r_state        <= c_st_run;
                        end else begin
                            r_state        <= c_st_release;
                        end
                    end else begin
                        r_seq <= r_seq + c_seq_one;
                    end
                end
                c_st_release: begin
                    if (r_seq == c_stg_last) begin
                        r_seq    <= '0;
                        r_ch_rst <= w_ch_shift;
                        if (w_ch_shift == '0) begin
                            r_all_released <= 1'b1;
                            r_state        <= c_st_run;
                        end
                    end else begin
                        r_seq <= r_seq + c_seq_one;
                    end
                end
                c_st_run: begin
                    if (bus.run_en && !w_cnt_sat) begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                    if (w_timeout) begin
                        r_stop_req <= 1'b1;
                        r_state    <= c_st_stopped;
                    end
                end
                default: begin
                    r_state <= c_st_stopped;
                end
            endcase
        end
    end

    assign bus.state        = r_state;
    assign bus.ch_rst       = r_ch_rst;
    assign bus.all_released = r_all_released;
    assign bus.stop_req     = r_stop_req;
    assign bus.cycle_cnt    = r_cnt;
endmodule
`default_nettype wire

// File: tb/tb_rst_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rst_seq_ctrl
// Description : Scoreboard bench for rst_seq_ctrl (default and 4-channel builds).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rst_seq_ctrl;
    typedef struct {
        int          edge_n;
        logic [1:0]  st;
        logic [3:0]  ch;
        logic        ar;
        logic        sr;
        logic [15:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   edge_a;
    int   edge_b;
    int   checks = 0;
    int   errors = 0;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea;
    exp_t eb;
    logic [5:0]  last_a = 'x;
    logic [11:0] last_b = 'x;
    logic [5:0]  va;
    logic [11:0] vb;

    rst_seq_ctrl_if #(.NUM_CH(2), .CNT_W(16)) bus_a ();
    rst_seq_ctrl_if #(.NUM_CH(4), .CNT_W(4))  bus_b ();

    rst_seq_ctrl u_dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (bus_a)
    );

    rst_seq_ctrl #(
        .NUM_CH         (4),
        .STAGGER_CYCLES (0),
        .RUN_CYCLES     (0),
        .CNT_W          (4)
    ) u_dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b)
    );

    always #10 clk = ~clk;

    always @(posedge clk or posedge rst_a)
        if (rst_a) edge_a <= 0; else edge_a <= edge_a + 1;

    always @(posedge clk or posedge rst_b)
        if (rst_b) edge_b <= 0; else edge_b <= edge_b + 1;

    function automatic void push_a(int n, logic [1:0] st, logic [3:0] ch, logic ar, logic sr, logic [15:0] cnt);
        qa.push_back('{edge_n: n, st: st, ch: ch, ar: ar, sr: sr, cnt: cnt});
    endfunction

    function automatic void push_b(int n, logic [1:0] st, logic [3:0] ch, logic ar, logic sr, logic [15:0] cnt);
        qb.push_back('{edge_n: n, st: st, ch: ch, ar: ar, sr: sr, cnt: cnt});
    endfunction

    task automatic check_evt(string nm, int n, logic [1:0] st, logic [3:0] ch, logic ar, logic sr,
                             logic [15:0] cnt, exp_t e);
        checks++;
        if (n !== e.edge_n || st !== e.st || ch !== e.ch || ar !== e.ar || sr !== e.sr || cnt !== e.cnt) begin
            errors++;
            $display("FAIL %s: got edge=%0d state=%0d ch_rst=%b all_rel=%b stop=%b cnt=%0d, expected edge=%0d state=%0d ch_rst=%b all_rel=%b stop=%b cnt=%0d",
                     nm, n, st, ch, ar, sr, cnt, e.edge_n, e.st, e.ch, e.ar, e.sr, e.cnt);
        end
    endtask

    // Monitors: every change of the observed outputs must match the next expected event.
    always @(negedge clk) begin
        va = {bus_a.state, bus_a.ch_rst, bus_a.all_released, bus_a.stop_req};
        if (va !== last_a) begin
            last_a = va;
            if (qa.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_a: got edge=%0d state=%0d ch_rst=%b, expected no change",
                         edge_a, bus_a.state, bus_a.ch_rst);
            end else begin
                ea = qa.pop_front();
                check_evt("mon_a", edge_a, bus_a.state, {2'b00, bus_a.ch_rst}, bus_a.all_released,
                          bus_a.stop_req, bus_a.cycle_cnt, ea);
            end
        end
    end

    always @(negedge clk) begin
        vb = {bus_b.state, bus_b.ch_rst, bus_b.all_released, bus_b.stop_req, bus_b.cycle_cnt};
        if (vb !== last_b) begin
            last_b = vb;
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_b: got edge=%0d state=%0d ch_rst=%b cnt=%0d, expected no change",
                         edge_b, bus_b.state, bus_b.ch_rst, bus_b.cycle_cnt);
            end else begin
                eb = qb.pop_front();
                check_evt("mon_b", edge_b, bus_b.state, bus_b.ch_rst, bus_b.all_released,
                          bus_b.stop_req, {12'd0, bus_b.cycle_cnt}, eb);
            end
        end
    end

    task automatic to_edge(input int n);
        while (edge_a < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic restart();
        push_a(0, 2'd0, 4'b0011, 1'b0, 1'b0, 16'd0);
        @(posedge clk);
        #5 rst_a = 1'b1;
        repeat (2) @(posedge clk);
        #15 rst_a = 1'b0;
    endtask

    task automatic check_now(string nm, int n, logic [1:0] st, logic [3:0] ch, logic ar, logic sr, logic [15:0] cnt);
        exp_t e;
        e = '{edge_n: n, st: st, ch: ch, ar: ar, sr: sr, cnt: cnt};
        check_evt(nm, edge_a, bus_a.state, {2'b00, bus_a.ch_rst}, bus_a.all_released,
                  bus_a.stop_req, bus_a.cycle_cnt, e);
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.sw_rst_req = 1'b0;
        bus_a.run_en     = 1'b1;
        bus_b.sw_rst_req = 1'b0;
        bus_b.run_en     = 1'b1;

        // 4-channel build: simultaneous release, counter saturates at 15, never stops
        push_b(0, 2'd0, 4'b1111, 1'b0, 1'b0, 16'd0);
        push_b(10, 2'd2, 4'b0000, 1'b1, 1'b0, 16'd0);
        for (int k = 1; k <= 15; k++) push_b(10 + k, 2'd2, 4'b0000, 1'b1, 1'b0, 16'(k));

        // Default build: power-on, then async reset at edge 300 and a full replay
        push_a(0, 2'd0, 4'b0011, 1'b0, 1'b0, 16'd0);
        push_a(10, 2'd1, 4'b0010, 1'b0, 1'b0, 16'd0);
        push_a(14, 2'd2, 4'b0000, 1'b1, 1'b0, 16'd0);
        #195;
        rst_a = 1'b0;
        rst_b = 1'b0;
        to_edge(300);
        push_a(0, 2'd0, 4'b0011, 1'b0, 1'b0, 16'd0);
        #4 rst_a = 1'b1;
        #1 check_now("async_rst", 0, 2'd0, 4'b0011, 1'b0, 1'b0, 16'd0);
        #29 rst_a = 1'b0;
        push_a(10, 2'd1, 4'b0010, 1'b0, 1'b0, 16'd0);
        push_a(14, 2'd2, 4'b0000, 1'b1, 1'b0, 16'd0);
        push_a(514, 2'd3, 4'b0000, 1'b1, 1'b1, 16'd500);
        to_edge(530);
        check_now("stopped_hold", 530, 2'd3, 4'b0000, 1'b1, 1'b1, 16'd500);

        // run_en high on odd edges only
        restart();
        push_a(10, 2'd1, 4'b0010, 1'b0, 1'b0, 16'd0);
        push_a(14, 2'd2, 4'b0000, 1'b1, 1'b0, 16'd0);
        push_a(1013, 2'd3, 4'b0000, 1'b1, 1'b1, 16'd500);
        bus_a.run_en = 1'b1;
        while (edge_a < 1020) begin
            to_edge(edge_a + 1);
            bus_a.run_en = ((edge_a + 1) % 2) == 1;
        end
        check_now("toggle_hold", 1020, 2'd3, 4'b0000, 1'b1, 1'b1, 16'd500);
        bus_a.run_en = 1'b1;

        // sw_rst_req pulse mid-release at edge 12
        restart();
        push_a(10, 2'd1, 4'b0010, 1'b0, 1'b0, 16'd0);
        push_a(12, 2'd0, 4'b0011, 1'b0, 1'b0, 16'd0);
        push_a(22, 2'd1, 4'b0010, 1'b0, 1'b0, 16'd0);
        push_a(26, 2'd2, 4'b0000, 1'b1, 1'b0, 16'd0);
        to_edge(11);
        bus_a.sw_rst_req = 1'b1;
        to_edge(12);
        bus_a.sw_rst_req = 1'b0;
        to_edge(30);

        // sw_rst_req on the timeout edge beats stop_req, then a replay
        restart();
        push_a(10, 2'd1, 4'b0010, 1'b0, 1'b0, 16'd0);
        push_a(14, 2'd2, 4'b0000, 1'b1, 1'b0, 16'd0);
        push_a(514, 2'd0, 4'b0011, 1'b0, 1'b0, 16'd0);
        push_a(524, 2'd1, 4'b0010, 1'b0, 1'b0, 16'd0);
        push_a(528, 2'd2, 4'b0000, 1'b1, 1'b0, 16'd0);
        push_a(1028, 2'd3, 4'b0000, 1'b1, 1'b1, 16'd500);
        to_edge(513);
        bus_a.sw_rst_req = 1'b1;
        to_edge(514);
        bus_a.sw_rst_req = 1'b0;
        to_edge(1035);

        // sw_rst_req on the last release edge, then held for edges 20..30
        restart();
        push_a(10, 2'd1, 4'b0010, 1'b0, 1'b0, 16'd0);
        push_a(14, 2'd0, 4'b0011, 1'b0, 1'b0, 16'd0);
        push_a(40, 2'd1, 4'b0010, 1'b0, 1'b0, 16'd0);
        push_a(44, 2'd2, 4'b0000, 1'b1, 1'b0, 16'd0);
        to_edge(13);
        bus_a.sw_rst_req = 1'b1;
        to_edge(14);
        bus_a.sw_rst_req = 1'b0;
        to_edge(19);
        bus_a.sw_rst_req = 1'b1;
        to_edge(30);
        bus_a.sw_rst_req = 1'b0;
        to_edge(50);

        checks++;
        if (qa.size() != 0) begin
            errors++;
            $display("FAIL pending_a: got %0d unseen events, expected 0", qa.size());
        end
        checks++;
        if (qb.size() != 0) begin
            errors++;
            $display("FAIL pending_b: got %0d unseen events, expected 0", qb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
